pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Parametrised multi-PLL bring-up and lock supervisor that runs in the reference-clock domain.
- For each of N_PLL channels it:
  - drives the PLL reset;
  - synchronises and debounces the PLL locked flag;
  - retries on lock timeout and declares a fault after MAX_RETRY attempts;
  - re-sequences automatically on loss of lock.
- Sits beside the PLL wrappers and gates downstream datapath resets through chan_ready/all_ready.

Parameters:
- N_PLL, 4, number of supervised PLL channels (1..16).
- SYNC_STAGES, 2, synchroniser depth on each locked input (>=2).
- RST_CYCLES, 16, PLL reset pulse width in refclk cycles (>=1).
- DEBOUNCE_CYCLES, 1024, consecutive synchronised-locked cycles required before ready (>=1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry (>=2).
- MAX_RETRY, 3, failed lock attempts before FAULT (1..255).
- CNT_W, 8, width of each relock counter.

Ports:
- refclk  in  1  reference clock; the only clock.
- rst_n  in  1  asynchronous active-low reset; deassertion is externally synchronised to refclk.
- locked_async  in  N_PLL  per-PLL locked flags, asynchronous to refclk.
- chan_en  in  N_PLL  per-channel enable (level).
- force_reset  in  N_PLL  per-channel single-cycle request to re-sequence.
- pll_rst  out  N_PLL  active-high PLL reset, one per channel.
- chan_ready  out  N_PLL  channel locked and debounced.
- chan_fault  out  N_PLL  channel exhausted its retries.
- all_ready  out  1  every enabled channel ready, with at least one enabled.
- relock_count  out  N_PLL*CNT_W  per-channel saturating count of lock losses from READY; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n=0):
  - pll_rst = all 1; chan_ready, chan_fault, all_ready = 0; relock_count = 0.
  - Synchronisers cleared; all channels go to IDLE with timers and retry counters at 0.
- Channels are independent and share no state except all_ready.
- locked_s[i] is locked_async[i] after SYNC_STAGES flops.
- Per-channel FSM states: IDLE, ASSERT_RST, WAIT_LOCK, DEBOUNCE, READY, FAULT. All outputs are registered.
- Priority each cycle: chan_en=0 > force_reset=1 > timer/lock events.
- Any state with chan_en=0: next state IDLE, with retry counter and timer cleared. relock_count is held.
- IDLE:
  - pll_rst=1.
  - chan_en=1 → ASSERT_RST, timer=0, retry=0.
- ASSERT_RST:
  - pll_rst=1 for exactly RST_CYCLES cycles, then → WAIT_LOCK with timer=0.
- WAIT_LOCK:
  - pll_rst=0.
  - locked_s=1 → DEBOUNCE with timer=0.
  - Otherwise the timer reaches LOCK_TIMEOUT-1:
    - if retry+1==MAX_RETRY → FAULT;
    - else retry++ → ASSERT_RST.
- DEBOUNCE:
  - pll_rst=0.
  - locked_s=0 → WAIT_LOCK with timer=0; retry is unchanged.
  - After DEBOUNCE_CYCLES consecutive locked_s=1 cycles → READY.
- READY:
  - chan_ready=1, pll_rst=0.
  - locked_s=0 → ASSERT_RST, retry=0, relock_count saturating increment (holds at 2^CNT_W-1).
  - force_reset=1 → ASSERT_RST with no count increment.
  - chan_ready drops on the same edge that pll_rst rises.
- FAULT:
  - pll_rst=1, chan_fault=1. The channel stays here until chan_en=0 or force_reset=1.
  - force_reset=1 → ASSERT_RST with retry=0 and chan_fault cleared.
- force_reset in IDLE is ignored. In ASSERT_RST it restarts the pulse with timer=0.
- Latency: locked_async held high from sampling edge k → chan_ready high at edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Lock loss in READY: locked_async low sampled at edge k → pll_rst=1 and chan_ready=0 at edge k+SYNC_STAGES+1.
- all_ready:
  - Registered; one cycle behind chan_ready/chan_en.
  - Equals 1 when (chan_ready | ~chan_en) is all ones and chan_en != 0.
  - A channel in FAULT while enabled forces all_ready=0.
- Glitches on locked_async shorter than one refclk cycle may or may not be seen. If seen, they behave as a real lock loss; no filtering beyond debounce is applied.

Test Plan:
All cases use N_PLL=2, SYNC_STAGES=2, RST_CYCLES=4, DEBOUNCE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRY=3.
- Reset and enable:
  - Stimulus: release rst_n with chan_en=2'b01; raise locked_async[0] 10 cycles after pll_rst[0] falls.
  - Required: pll_rst[0]=1 for exactly 4 cycles after IDLE exit; chan_ready[0] rises 11 edges after locked_async[0] is first sampled high; all_ready=1 one cycle later; pll_rst[1] stays 1.
- Timeout and fault:
  - Stimulus: chan_en[1]=1 with locked_async[1]=0 throughout.
  - Required: three pll_rst[1] pulses of 4 cycles, each separated by 32 low cycles; then chan_fault[1]=1, pll_rst[1]=1, all_ready=0. A force_reset[1] pulse clears chan_fault[1] and restarts the sequence.
- Debounce abort:
  - Stimulus: hold locked_async[0] high for 5 cycles, drop it for 3 cycles, then hold it high.
  - Required: no chan_ready[0] pulse; ready only 8 debounce cycles after the final rise; retry count unaffected.
- Lock loss and counter:
  - Stimulus: with channel 0 READY, drop locked_async[0] four times, re-locking after each drop.
  - Required: pll_rst[0] rises 3 edges after each drop; relock_count[7:0]=4. With CNT_W=2, the count saturates at 3.
- Priority:
  - Stimulus: in READY, assert force_reset[0] and drop chan_en[0] in the same cycle.
  - Required: next state IDLE; pll_rst[0]=1; no relock increment.
- Async reset mid-sequence:
  - Stimulus: assert rst_n=0 during DEBOUNCE.
  - Required: all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: per-channel PLL reset sequencing, lock debounce, retry/fault and relock supervision
module pll_lock_sequencer #(
    parameter int N_PLL           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int RST_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int MAX_RETRY       = 3,
    parameter int CNT_W           = 8
) (
    input  logic                     refclk,
    input  logic                     rst_n,
    input  logic [N_PLL-1:0]         locked_async,
    input  logic [N_PLL-1:0]         chan_en,
    input  logic [N_PLL-1:0]         force_reset,
    output logic [N_PLL-1:0]         pll_rst,
    output logic [N_PLL-1:0]         chan_ready,
    output logic [N_PLL-1:0]         chan_fault,
    output logic                     all_ready,
    output logic [N_PLL*CNT_W-1:0]   relock_count
);
    typedef enum logic [2:0] {IDLE, ASSERT_RST, WAIT_LOCK, DEBOUNCE, READY, FAULT} state_t;
    localparam int MAX_A   = RST_CYCLES > DEBOUNCE_CYCLES ? RST_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAX_CYC = MAX_A > LOCK_TIMEOUT ? MAX_A : LOCK_TIMEOUT;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
    logic all_ready_d, all_ready_q;
    for (genvar i = 0; i < N_PLL; i++) begin : g_chan
        state_t                 state_q, state_d;
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [TW-1:0]          timer_q, timer_d;
        logic [7:0]             retry_q, retry_d;
        logic [CNT_W-1:0]       relock_q, relock_d;
        logic                   pll_rst_q, pll_rst_d, chan_ready_q, chan_ready_d, chan_fault_q, chan_fault_d;
        logic                   locked_s;
        assign locked_s = sync_q[SYNC_STAGES-1];
        // next state: enable beats force_reset, which beats timer and lock events; outputs decode the current state
        always_comb begin
            sync_d       = {sync_q[SYNC_STAGES-2:0], locked_async[i]};
            state_d      = state_q;
            timer_d      = state_q inside {ASSERT_RST, WAIT_LOCK, DEBOUNCE} ? timer_q + TW'(1) : '0;
            retry_d      = retry_q;
            relock_d     = relock_q;
            pll_rst_d    = state_q inside {IDLE, ASSERT_RST, FAULT};
            chan_ready_d = state_q == READY;
            chan_fault_d = state_q == FAULT;
            if (!chan_en[i]) begin
                state_d = IDLE;
                timer_d = '0;
                retry_d = '0;
            end else if (force_reset[i] && state_q != IDLE) begin
                state_d = ASSERT_RST;
                timer_d = '0;
                retry_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = ASSERT_RST;
                        timer_d = '0;
                        retry_d = '0;
                    end
                    ASSERT_RST: if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end
                    WAIT_LOCK: if (locked_s) begin
                        state_d = DEBOUNCE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        timer_d = '0;
                        state_d = ({1'b0, retry_q} + 9'd1 == 9'(MAX_RETRY)) ? FAULT : ASSERT_RST;
                        retry_d = retry_q + 8'd1;
                    end
                    DEBOUNCE: if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == DEB_LAST) state_d = READY;
                    READY: if (!locked_s) begin
                        state_d  = ASSERT_RST;
                        timer_d  = '0;
                        retry_d  = '0;
                        relock_d = (&relock_q) ? relock_q : relock_q + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
        // channel state, synchroniser and registered outputs
        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                state_q      <= IDLE;
                sync_q       <= '0;
                timer_q      <= '0;
                retry_q      <= '0;
                relock_q     <= '0;
                pll_rst_q    <= 1'b1;
                chan_ready_q <= 1'b0;
                chan_fault_q <= 1'b0;
            end else begin
                state_q      <= state_d;
                sync_q       <= sync_d;
                timer_q      <= timer_d;
                retry_q      <= retry_d;
                relock_q     <= relock_d;
                pll_rst_q    <= pll_rst_d;
                chan_ready_q <= chan_ready_d;
                chan_fault_q <= chan_fault_d;
            end
        end
        assign pll_rst[i]                      = pll_rst_q;
        assign chan_ready[i]                   = chan_ready_q;
        assign chan_fault[i]                   = chan_fault_q;
        assign relock_count[i*CNT_W +: CNT_W]  = relock_q;
    end
    // every enabled channel ready, and at least one enabled
    always_comb begin
        all_ready_d = (&(chan_ready | ~chan_en)) && (|chan_en);
    end
    // registered aggregate ready
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) all_ready_q <= 1'b0;
        else all_ready_q <= all_ready_d;
    end
    assign all_ready = all_ready_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: randomized scoreboard bench with a deadline-based channel model
module tb_pll_lock_sequencer;
    localparam int NP = 2, SS = 2, RC = 4, DB = 8, TO = 32, MR = 3, CW = 8, RMAX = 255;
    localparam int W = 3*NP + 1 + NP*CW;
    localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_DEB = 3, P_READY = 4, P_FAULT = 5;
    logic refclk, rst_n, all_ready;
    logic [NP-1:0] locked_async, chan_en, force_reset, pll_rst, chan_ready, chan_fault;
    logic [NP*CW-1:0] relock_count;
    int checks = 0, errors = 0, cyc = 0, k, drops = 0, run;
    int ph[NP], dl[NP], tries[NP], rel[NP];
    logic [NP-1:0] prev_rdy, ls, o_rst, o_rdy, o_flt;
    logic o_all, prev, seen;
    logic [NP*CW-1:0] o_rel;
    logic [NP-1:0] lhist[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_v, act_v;
    int lows[$], highs[$];

    pll_lock_sequencer #(.N_PLL(NP), .SYNC_STAGES(SS), .RST_CYCLES(RC), .DEBOUNCE_CYCLES(DB),
        .LOCK_TIMEOUT(TO), .MAX_RETRY(MR), .CNT_W(CW)) dut (
        .refclk(refclk), .rst_n(rst_n), .locked_async(locked_async), .chan_en(chan_en),
        .force_reset(force_reset), .pll_rst(pll_rst), .chan_ready(chan_ready),
        .chan_fault(chan_fault), .all_ready(all_ready), .relock_count(relock_count));

    initial begin
        refclk = 0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endfunction

    // one channel advanced by one refclk edge; each timed phase ends at an absolute edge number
    function automatic void step(int c, logic lk);
        if (!chan_en[c]) begin
            ph[c] = P_IDLE; tries[c] = 0;
        end else if (force_reset[c] && ph[c] != P_IDLE) begin
            ph[c] = P_RST; dl[c] = cyc + RC; tries[c] = 0;
        end else begin
            case (ph[c])
                P_IDLE: begin ph[c] = P_RST; dl[c] = cyc + RC; tries[c] = 0; end
                P_RST: if (cyc == dl[c]) begin ph[c] = P_WAIT; dl[c] = cyc + TO; end
                P_WAIT: begin
                    if (lk) begin ph[c] = P_DEB; dl[c] = cyc + DB; end
                    else if (cyc == dl[c]) begin
                        tries[c]++;
                        if (tries[c] == MR) ph[c] = P_FAULT;
                        else begin ph[c] = P_RST; dl[c] = cyc + RC; end
                    end
                end
                P_DEB: begin
                    if (!lk) begin ph[c] = P_WAIT; dl[c] = cyc + TO; end
                    else if (cyc == dl[c]) ph[c] = P_READY;
                end
                P_READY: if (!lk) begin
                    ph[c] = P_RST; dl[c] = cyc + RC; tries[c] = 0;
                    if (rel[c] < RMAX) rel[c]++;
                end
                default: ;
            endcase
        end
    endfunction

    // reference model: pushes the outputs expected after every edge
    always @(posedge refclk) begin
        cyc++;
        ls = (lhist.size() == SS) ? lhist[0] : '0;
        if (!rst_n) begin
            lhist.delete();
            for (int c = 0; c < NP; c++) begin ph[c] = P_IDLE; tries[c] = 0; rel[c] = 0; end
            prev_rdy = '0;
            sb.push_back({{NP{1'b1}}, {NP{1'b0}}, {NP{1'b0}}, 1'b0, {NP*CW{1'b0}}});
        end else begin
            lhist.push_back(locked_async);
            if (lhist.size() > SS) void'(lhist.pop_front());
            for (int c = 0; c < NP; c++) begin
                o_rst[c] = ph[c] inside {P_IDLE, P_RST, P_FAULT};
                o_rdy[c] = ph[c] == P_READY;
                o_flt[c] = ph[c] == P_FAULT;
                step(c, ls[c]);
                o_rel[c*CW +: CW] = CW'(rel[c]);
            end
            o_all = (&(prev_rdy | ~chan_en)) && (|chan_en);
            prev_rdy = o_rdy;
            sb.push_back({o_rst, o_rdy, o_flt, o_all, o_rel});
        end
    end

    // monitor: compares every presented output word against the scoreboard
    always @(negedge refclk) begin
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {pll_rst, chan_ready, chan_fault, all_ready, relock_count};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL scoreboard edge %0d: dut %h model %h", cyc, act_v, exp_v);
            end
        end
    end

    task automatic lose_lock();
        locked_async[0] = 1'b0;
        drops++;
        k = cyc + 1;
        for (int n = 0; n < 20 && !pll_rst[0]; n++) @(negedge refclk);
        chk("loss_rst_delay", cyc - k, 3);
        chk("loss_ready_drop", 32'(chan_ready[0]), 0);
    endtask

    task automatic relock_cycle();
        repeat ($urandom_range(0, 5)) @(negedge refclk);
        lose_lock();
        locked_async[0] = 1'b1;
        for (int n = 0; n < 60 && !chan_ready[0]; n++) @(negedge refclk);
        chk("relock_ready", 32'(chan_ready[0]), 1);
    endtask

    initial begin
        rst_n = 0; chan_en = '0; force_reset = '0; locked_async = '0;
        repeat (3) @(negedge refclk);
        chk("reset_pll_rst", 32'(pll_rst), 3);
        chk("reset_flags", 32'({chan_ready, chan_fault, all_ready}), 0);
        chk("reset_relock", 32'(relock_count), 0);
        // bring-up of channel 0
        chan_en = 2'b01; rst_n = 1;
        for (int n = 0; n < 40 && pll_rst[0]; n++) @(negedge refclk);
        chk("t1_rst0_fall", 32'(pll_rst[0]), 0);
        chk("t1_rst1_held", 32'(pll_rst[1]), 1);
        repeat (9) @(negedge refclk);
        locked_async[0] = 1'b1;
        k = cyc + 1;
        for (int n = 0; n < 40 && !chan_ready[0]; n++) @(negedge refclk);
        chk("t1_ready_latency", cyc - k, 11);
        @(negedge refclk);
        chk("t1_all_ready", 32'(all_ready), 1);
        // channel 1 never locks: three reset pulses then fault
        chan_en = 2'b11;
        prev = pll_rst[1]; run = 0;
        for (int n = 0; n < 300 && !chan_fault[1]; n++) begin
            @(negedge refclk);
            if (pll_rst[1] == prev) run++;
            else begin
                if (prev) highs.push_back(run); else lows.push_back(run);
                prev = pll_rst[1]; run = 1;
            end
        end
        chk("t2_low_runs", lows.size(), 3);
        foreach (lows[i]) chk($sformatf("t2_low_width_%0d", i), lows[i], TO);
        chk("t2_high_runs", highs.size(), 3);
        for (int i = 1; i < highs.size(); i++) chk($sformatf("t2_pulse_width_%0d", i), highs[i], RC);
        chk("t2_fault", 32'(chan_fault[1]), 1);
        chk("t2_fault_rst", 32'(pll_rst[1]), 1);
        chk("t2_all_ready", 32'(all_ready), 0);
        force_reset[1] = 1'b1;
        @(negedge refclk);
        force_reset = '0;
        @(negedge refclk);
        chk("t2_fault_cleared", 32'(chan_fault[1]), 0);
        chk("t2_restart_rst", 32'(pll_rst[1]), 1);
        chan_en[1] = 1'b0;
        // debounce abort on channel 0
        lose_lock();
        for (int n = 0; n < 20 && pll_rst[0]; n++) @(negedge refclk);
        seen = 0;
        locked_async[0] = 1'b1;
        repeat (5) begin @(negedge refclk); seen |= chan_ready[0]; end
        locked_async[0] = 1'b0;
        repeat (3) begin @(negedge refclk); seen |= chan_ready[0]; end
        locked_async[0] = 1'b1;
        k = cyc + 1;
        for (int n = 0; n < 40 && !chan_ready[0]; n++) begin @(negedge refclk); seen |= 1'b0; end
        chk("t3_no_early_ready", 32'(seen), 0);
        chk("t3_ready_latency", cyc - k, 11);
        chk("t3_relock", 32'(relock_count[CW-1:0]), drops);
        // repeated lock losses
        for (int d = 0; d < 3; d++) relock_cycle();
        chk("t4_relock4", 32'(relock_count[CW-1:0]), 4);
        // disable wins over force_reset in READY
        force_reset[0] = 1'b1; chan_en[0] = 1'b0;
        @(negedge refclk);
        force_reset = '0;
        @(negedge refclk);
        chk("t5_pll_rst", 32'(pll_rst[0]), 1);
        chk("t5_ready", 32'(chan_ready[0]), 0);
        chk("t5_relock", 32'(relock_count[CW-1:0]), 4);
        chan_en[0] = 1'b1;
        for (int n = 0; n < 60 && !chan_ready[0]; n++) @(negedge refclk);
        chk("t5_reready", 32'(chan_ready[0]), 1);
        // saturation of the relock counter
        for (int d = 0; d < 256; d++) relock_cycle();
        chk("t4_relock_sat", 32'(relock_count[CW-1:0]), RMAX);
        // randomized traffic on both channels
        for (int n = 0; n < 3000; n++) begin
            @(negedge refclk);
            force_reset = '0;
            for (int c = 0; c < NP; c++) begin
                if ($urandom_range(0, 199) == 0) chan_en[c] = ~chan_en[c];
                if ($urandom_range(0, 119) == 0) force_reset[c] = 1'b1;
                if (locked_async[c]) begin
                    if ($urandom_range(0, 39) == 0) locked_async[c] = 1'b0;
                end else if ($urandom_range(0, 24) == 0) locked_async[c] = 1'b1;
            end
        end
        // asynchronous reset while channel 0 debounces
        @(negedge refclk);
        force_reset = '0; chan_en = '0; locked_async = '0;
        repeat (2) @(negedge refclk);
        chan_en = 2'b01;
        for (int n = 0; n < 40 && pll_rst[0]; n++) @(negedge refclk);
        repeat (3) @(negedge refclk);
        locked_async[0] = 1'b1;
        repeat (5) @(negedge refclk);
        #2 rst_n = 0;
        #1;
        chk("t6_async_pll_rst", 32'(pll_rst), 3);
        chk("t6_async_flags", 32'({chan_ready, chan_fault, all_ready}), 0);
        chk("t6_async_relock", 32'(relock_count), 0);
        repeat (3) @(negedge refclk);
        rst_n = 1;
        repeat (10) @(negedge refclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
